// File: rtl/fifo_sync_param_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
// Benches pick the read mode through fifo_mode_e.
package fifo_sync_param_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so both 0 and DEPTH are representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
// slave = FIFO side, master = the logic driving writes and reads.
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// FIFO storage: DATA_W x DEPTH register array with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module fifo_mem_dp
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read,
// programmable almost flags, fill count and sticky overflow/underflow flags.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [PTR_W-1:0]  count_w;
    logic              full_w;
    logic              empty_w;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Status comes purely from the registered pointers; the extra MSB
    // separates the full case from the empty case when addresses match.
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_acc = bus.wr_en && !full_w;
    assign rd_acc = bus.rd_en && !empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A fresh error event outranks a clear in the same cycle.
        if (bus.wr_en && full_w) begin
            overflow_d = 1'b1;
        end else if (bus.err_clr) begin
            overflow_d = 1'b0;
        end
        if (bus.rd_en && empty_w) begin
            underflow_d = 1'b1;
        end else if (bus.err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
            // Head word is presented directly; masked to zero while empty so
            // stale memory never leaks onto the bus.
            assign bus.rd_data  = empty_w ? '0 : mem_rdata;
            assign bus.rd_valid = !empty_w;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) begin
                    rd_data_d = mem_rdata;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.count        = count_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_w >= PTR_W'(AF_THRESH));
    assign bus.almost_empty = (count_w <= PTR_W'(AE_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
